emif_avmm_arb: RTL and testbench



---
 rtl/emif_avmm_arb.sv | 202 ++++++++++++++++++++
 tb/tb_emif_avmm_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/emif_avmm_arb.sv
// emif_avmm_arb: two-port Avalon-MM arbiter for one EMIF bank user port.
// Round-robin between s0 (AFU) and s1 (FIM); write bursts lock the grant;
// read responses are steered back in order via an outstanding-read FIFO.
// Optional grant counters: define EMIF_AVMM_ARB_PERF_EN.
module emif_avmm_arb #(
    parameter int ADDR_WIDTH       = 27,
    parameter int DATA_WIDTH       = 512,
    parameter int BURSTCOUNT_WIDTH = 7,
    parameter int RSP_FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s0_read,
    input  logic                        s0_write,
    input  logic [ADDR_WIDTH-1:0]       s0_address,
    input  logic [BURSTCOUNT_WIDTH-1:0] s0_burstcount,
    input  logic [DATA_WIDTH-1:0]       s0_writedata,
    input  logic [DATA_WIDTH/8-1:0]     s0_byteenable,
    output logic                        s0_waitrequest,
    output logic [DATA_WIDTH-1:0]       s0_readdata,
    output logic                        s0_readdatavalid,
    input  logic                        s1_read,
    input  logic                        s1_write,
    input  logic [ADDR_WIDTH-1:0]       s1_address,
    input  logic [BURSTCOUNT_WIDTH-1:0] s1_burstcount,
    input  logic [DATA_WIDTH-1:0]       s1_writedata,
    input  logic [DATA_WIDTH/8-1:0]     s1_byteenable,
    output logic                        s1_waitrequest,
    output logic [DATA_WIDTH-1:0]       s1_readdata,
    output logic                        s1_readdatavalid,
    output logic                        m_read,
    output logic                        m_write,
    output logic [ADDR_WIDTH-1:0]       m_address,
    output logic [BURSTCOUNT_WIDTH-1:0] m_burstcount,
    output logic [DATA_WIDTH-1:0]       m_writedata,
    output logic [DATA_WIDTH/8-1:0]     m_byteenable,
    input  logic                        m_waitrequest,
    input  logic [DATA_WIDTH-1:0]       m_readdata,
    input  logic                        m_readdatavalid,
    output logic                        rsp_err,
    output logic [31:0]                 s0_grant_cnt,
    output logic [31:0]                 s1_grant_cnt
);
    localparam int BCW  = BURSTCOUNT_WIDTH;
    localparam int PTRW = $clog2(RSP_FIFO_DEPTH);
    localparam logic [BCW-1:0] BC_ONE = BCW'(1);

    typedef enum logic {ARB, WR_BURST} state_t;

    state_t         state, state_nxt;
    logic           rr_ptr, rr_ptr_nxt;
    logic           burst_port, burst_port_nxt;
    logic [BCW-1:0] beats_left, beats_left_nxt;

    logic           gnt, sel_read, sel_write, rd_only, rd_block, gnt_wait, accept;
    logic [BCW-1:0] sel_bc, sel_bc_eff;

    logic [BCW:0]   fifo_mem [RSP_FIFO_DEPTH];
    logic [PTRW:0]  wr_ptr, rd_ptr;
    logic [BCW-1:0] rsp_beats, head_bc;
    logic           head_port, fifo_full, fifo_empty, push, pop, rsp_hit;

    // Grant selection and command mux; reads are held off while full or while a burst owns the port
    always_comb begin
        gnt = rr_ptr;
        if (state == WR_BURST)
            gnt = burst_port;
        else if ((s0_read | s0_write) & (s1_read | s1_write))
            gnt = rr_ptr;
        else if (s0_read | s0_write)
            gnt = 1'b0;
        else if (s1_read | s1_write)
            gnt = 1'b1;

        sel_read     = gnt ? s1_read       : s0_read;
        sel_write    = gnt ? s1_write      : s0_write;
        sel_bc       = gnt ? s1_burstcount : s0_burstcount;
        m_address    = gnt ? s1_address    : s0_address;
        m_writedata  = gnt ? s1_writedata  : s0_writedata;
        m_byteenable = gnt ? s1_byteenable : s0_byteenable;
        m_burstcount = sel_bc;
        sel_bc_eff   = (sel_bc == '0) ? BC_ONE : sel_bc;

        rd_only  = sel_read & ~sel_write;
        rd_block = rd_only & (fifo_full | (state == WR_BURST));
        m_write  = ~reset & sel_write;
        m_read   = ~reset & rd_only & ~rd_block;
        gnt_wait = reset | m_waitrequest | rd_block;
        accept   = (m_read | m_write) & ~m_waitrequest;

        s0_waitrequest = gnt  ? 1'b1 : gnt_wait;
        s1_waitrequest = !gnt ? 1'b1 : gnt_wait;
    end

    // Next-state logic: round-robin pointer and burst lock
    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        burst_port_nxt = burst_port;
        beats_left_nxt = beats_left;
        case (state)
            ARB: begin
                if (accept) begin
                    rr_ptr_nxt = ~gnt;
                    if (m_write && sel_bc_eff != BC_ONE) begin
                        state_nxt      = WR_BURST;
                        burst_port_nxt = gnt;
                        beats_left_nxt = sel_bc_eff - BC_ONE;
                    end
                end
            end
            WR_BURST: begin
                if (accept) begin
                    beats_left_nxt = beats_left - BC_ONE;
                    if (beats_left == BC_ONE)
                        state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB;
            rr_ptr     <= 1'b0;
            burst_port <= 1'b0;
            beats_left <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            burst_port <= burst_port_nxt;
            beats_left <= beats_left_nxt;
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {PTRW{1'b0}}});
    assign head_port  = fifo_mem[rd_ptr[PTRW-1:0]][BCW];
    assign head_bc    = fifo_mem[rd_ptr[PTRW-1:0]][BCW-1:0];
    assign push       = m_read & ~m_waitrequest;
    assign rsp_hit    = m_readdatavalid & ~fifo_empty;
    assign pop        = rsp_hit & (rsp_beats == head_bc - BC_ONE);

    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;
    assign s0_readdatavalid = ~reset & rsp_hit & ~head_port;
    assign s1_readdatavalid = ~reset & rsp_hit & head_port;

    // Outstanding-read storage: {port, burstcount} per accepted read
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[PTRW-1:0]] <= {gnt, sel_bc_eff};
    end

    // FIFO pointers, head beat counter and sticky orphan-response flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rsp_beats <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                rsp_beats <= '0;
            end else if (rsp_hit) begin
                rsp_beats <= rsp_beats + BC_ONE;
            end
            if (m_readdatavalid && fifo_empty)
                rsp_err <= 1'b1;
        end
    end

`ifdef EMIF_AVMM_ARB_PERF_EN
    logic [31:0] cnt0, cnt1;
    logic        first_beat;
    assign first_beat = accept & (state == ARB);

    // Saturating per-port counters of accepted first beats
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (first_beat && !gnt && cnt0 != '1)
                cnt0 <= cnt0 + 1'b1;
            if (first_beat && gnt && cnt1 != '1)
                cnt1 <= cnt1 + 1'b1;
        end
    end
    assign s0_grant_cnt = cnt0;
    assign s1_grant_cnt = cnt1;
`else
    assign s0_grant_cnt = '0;
    assign s1_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_emif_avmm_arb.sv
// Self-checking bench for emif_avmm_arb: vector table, corner-case sequences
// and randomized traffic checked against a transaction-level model.
module tb_emif_avmm_arb;
    localparam int AW = 27;
    localparam int DW = 64;
    localparam int BW = 7;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    logic s0_read, s0_write, s1_read, s1_write;
    logic [AW-1:0] s0_address, s1_address, m_address;
    logic [BW-1:0] s0_burstcount, s1_burstcount, m_burstcount;
    logic [DW-1:0] s0_writedata, s1_writedata, m_writedata;
    logic [DW/8-1:0] s0_byteenable, s1_byteenable, m_byteenable;
    logic s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
    logic [DW-1:0] s0_readdata, s1_readdata, m_readdata;
    logic m_read, m_write, m_waitrequest, m_readdatavalid, rsp_err;
    logic [31:0] s0_grant_cnt, s1_grant_cnt;

    always #5 clk = ~clk;

    emif_avmm_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BW), .RSP_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .s0_read(s0_read), .s0_write(s0_write), .s0_address(s0_address),
        .s0_burstcount(s0_burstcount), .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
        .s1_read(s1_read), .s1_write(s1_write), .s1_address(s1_address),
        .s1_burstcount(s1_burstcount), .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_burstcount(m_burstcount),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .rsp_err(rsp_err),
        .s0_grant_cnt(s0_grant_cnt), .s1_grant_cnt(s1_grant_cnt)
    );

    // Simultaneous read and write on one port is illegal stimulus
    always @(negedge clk) begin
        if (reset === 1'b0)
            assert (!(s0_read && s0_write) && !(s1_read && s1_write))
                else $error("illegal read+write on one port");
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the port, what is outstanding, counters
    typedef struct { int port; int bc; } rd_t;
    rd_t    rq[$];
    int     lock_port = -1, lock_left = 0, head_beats = 0;
    bit     rr = 0, err = 0;
    longint cnt0 = 0, cnt1 = 0;

    bit cur_rst, cur_mw, cur_mrdv, e_mr, e_mw;
    int owner, owner_bc;

    task automatic step_a(input bit rst, r0, w0, r1, w1, input int b0, b1, input bit mw, mrdv);
        bit rd_o, wr_o, full, stall;
        bit [1:0] e_wait, e_rdv;
        logic [AW-1:0] e_addr;
        reset = rst; s0_read = r0; s0_write = w0; s1_read = r1; s1_write = w1;
        s0_burstcount = BW'(b0); s1_burstcount = BW'(b1);
        s0_address = AW'($urandom); s1_address = AW'($urandom);
        s0_writedata = {$urandom, $urandom}; s1_writedata = {$urandom, $urandom};
        m_readdata = {$urandom, $urandom};
        m_waitrequest = mw; m_readdatavalid = mrdv;
        cur_rst = rst; cur_mw = mw; cur_mrdv = mrdv;
        #4;
        if (lock_port >= 0) owner = lock_port;
        else if ((r0 | w0) && (r1 | w1)) owner = int'(rr);
        else if (r0 | w0) owner = 0;
        else if (r1 | w1) owner = 1;
        else owner = int'(rr);
        rd_o = owner ? (r1 && !w1) : (r0 && !w0);
        wr_o = owner ? w1 : w0;
        owner_bc = owner ? b1 : b0;
        if (owner_bc == 0) owner_bc = 1;
        e_addr = owner ? s1_address : s0_address;
        full = (rq.size() == DEPTH);
        e_mw = wr_o && !rst;
        e_mr = rd_o && !full && lock_port < 0 && !rst;
        stall = rst || mw || (rd_o && (full || lock_port >= 0));
        e_wait = 2'b11;
        if (!stall) e_wait[owner] = 1'b0;
        e_rdv = 2'b00;
        if (!rst && mrdv && rq.size() > 0) e_rdv[rq[0].port] = 1'b1;
        chk("s0_waitrequest", 64'(s0_waitrequest), 64'(e_wait[0]));
        chk("s1_waitrequest", 64'(s1_waitrequest), 64'(e_wait[1]));
        chk("m_read", 64'(m_read), 64'(e_mr));
        chk("m_write", 64'(m_write), 64'(e_mw));
        chk("s0_readdatavalid", 64'(s0_readdatavalid), 64'(e_rdv[0]));
        chk("s1_readdatavalid", 64'(s1_readdatavalid), 64'(e_rdv[1]));
        chk("rsp_err", 64'(rsp_err), 64'(err));
        if (e_mr || e_mw) chk("m_address", 64'(m_address), 64'(e_addr));
        if (e_rdv[0]) chk("s0_readdata", s0_readdata, m_readdata);
        if (e_rdv[1]) chk("s1_readdata", s1_readdata, m_readdata);
`ifdef EMIF_AVMM_ARB_PERF_EN
        chk("s0_grant_cnt", 64'(s0_grant_cnt), 64'(cnt0));
        chk("s1_grant_cnt", 64'(s1_grant_cnt), 64'(cnt1));
`else
        chk("s0_grant_cnt", 64'(s0_grant_cnt), 64'd0);
        chk("s1_grant_cnt", 64'(s1_grant_cnt), 64'd0);
`endif
    endtask

    task automatic step_b();
        @(posedge clk);
        if (cur_rst) begin
            lock_port = -1; lock_left = 0; rr = 0; rq.delete();
            head_beats = 0; err = 0; cnt0 = 0; cnt1 = 0;
        end else begin
            if (cur_mrdv) begin
                if (rq.size() == 0) err = 1;
                else begin
                    head_beats++;
                    if (head_beats == rq[0].bc) begin
                        void'(rq.pop_front());
                        head_beats = 0;
                    end
                end
            end
            if ((e_mr || e_mw) && !cur_mw) begin
                if (lock_port < 0) begin
                    rr = (owner == 0);
                    if (owner == 1) cnt1++; else cnt0++;
                    if (e_mw && owner_bc > 1) begin
                        lock_port = owner;
                        lock_left = owner_bc - 1;
                    end
                    if (e_mr) rq.push_back('{owner, owner_bc});
                end else begin
                    lock_left--;
                    if (lock_left == 0) lock_port = -1;
                end
            end
        end
        #1;
    endtask

    task automatic step(input bit rst, r0, w0, r1, w1, input int b0, b1, input bit mw, mrdv);
        step_a(rst, r0, w0, r1, w1, b0, b1, mw, mrdv);
        step_b();
    endtask

    typedef struct {
        bit rst, r0, w0, r1, w1; int b0, b1; bit mw, mrdv;
        bit e_w0, e_w1, e_mr, e_mw, e_rdv0, e_rdv1, e_err;
    } vec_t;
    vec_t tbl[18];

    initial begin
        s0_byteenable = '1; s1_byteenable = '1;
        reset = 1'b1; s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0;
        s0_burstcount = 1; s1_burstcount = 1; s0_address = '0; s1_address = '0;
        s0_writedata = '0; s1_writedata = '0;
        m_waitrequest = 0; m_readdatavalid = 0; m_readdata = '0;

        //        rst r0 w0 r1 w1 b0 b1 mw rdv | w0 w1 mr mw rv0 rv1 err
        tbl[0]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0,   0, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 1, 0, 1, 1, 0, 0,   0, 1, 1, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 1, 0, 1, 1, 0, 0,   1, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 1, 0, 1, 1, 0, 1,   0, 1, 1, 0, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 1, 1, 0, 1,   1, 0, 0, 0, 0, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 1, 0, 1,   1, 0, 0, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 1, 1, 0, 1,   1, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0,   1, 0, 0, 0, 0, 0, 1};
        tbl[9]  = '{0, 0, 1, 0, 0, 4, 1, 0, 0,   0, 1, 0, 1, 0, 0, 1};
        tbl[10] = '{0, 0, 1, 0, 1, 4, 1, 0, 0,   0, 1, 0, 1, 0, 0, 1};
        tbl[11] = '{0, 0, 1, 0, 1, 4, 1, 1, 0,   1, 1, 0, 1, 0, 0, 1};
        tbl[12] = '{0, 0, 1, 0, 1, 4, 1, 1, 0,   1, 1, 0, 1, 0, 0, 1};
        tbl[13] = '{0, 0, 1, 0, 1, 4, 1, 0, 0,   0, 1, 0, 1, 0, 0, 1};
        tbl[14] = '{0, 0, 1, 0, 1, 4, 1, 0, 0,   0, 1, 0, 1, 0, 0, 1};
        tbl[15] = '{0, 0, 1, 0, 1, 1, 1, 0, 0,   1, 0, 0, 1, 0, 0, 1};
        tbl[16] = '{1, 0, 0, 0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 1};
        tbl[17] = '{0, 0, 0, 0, 0, 1, 1, 0, 0,   0, 1, 0, 0, 0, 0, 0};

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            step_a(tbl[i].rst, tbl[i].r0, tbl[i].w0, tbl[i].r1, tbl[i].w1,
                   tbl[i].b0, tbl[i].b1, tbl[i].mw, tbl[i].mrdv);
            chk($sformatf("vec%0d s0_waitrequest", i), 64'(s0_waitrequest), 64'(tbl[i].e_w0));
            chk($sformatf("vec%0d s1_waitrequest", i), 64'(s1_waitrequest), 64'(tbl[i].e_w1));
            chk($sformatf("vec%0d m_read", i), 64'(m_read), 64'(tbl[i].e_mr));
            chk($sformatf("vec%0d m_write", i), 64'(m_write), 64'(tbl[i].e_mw));
            chk($sformatf("vec%0d s0_rdv", i), 64'(s0_readdatavalid), 64'(tbl[i].e_rdv0));
            chk($sformatf("vec%0d s1_rdv", i), 64'(s1_readdatavalid), 64'(tbl[i].e_rdv1));
            chk($sformatf("vec%0d rsp_err", i), 64'(rsp_err), 64'(tbl[i].e_err));
            step_b();
        end

        // FIFO full: 16 two-beat reads outstanding stall the 17th until one pops
        step(1, 0, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 0, 2, 1, 0, 0);
        step_a(0, 1, 0, 0, 0, 2, 1, 0, 0);
        chk("full s0_waitrequest", 64'(s0_waitrequest), 64'd1);
        chk("full m_read", 64'(m_read), 64'd0);
        step_b();
        step_a(0, 1, 0, 0, 0, 2, 1, 0, 1);
        chk("full beat1 s0_rdv", 64'(s0_readdatavalid), 64'd1);
        chk("full beat1 s0_waitrequest", 64'(s0_waitrequest), 64'd1);
        step_b();
        step(0, 1, 0, 0, 0, 2, 1, 0, 1);
        step_a(0, 1, 0, 0, 0, 2, 1, 0, 0);
        chk("after pop m_read", 64'(m_read), 64'd1);
        chk("after pop s0_waitrequest", 64'(s0_waitrequest), 64'd0);
        step_b();

        // Reset mid write burst (2 beats left) with 3 reads outstanding
        step(1, 0, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0, 4, 1, 0, 0);
        step(0, 0, 1, 0, 0, 4, 1, 0, 0);
        step_a(1, 0, 1, 0, 0, 4, 1, 0, 1);
        chk("rst s0_waitrequest", 64'(s0_waitrequest), 64'd1);
        chk("rst s1_waitrequest", 64'(s1_waitrequest), 64'd1);
        chk("rst m_write", 64'(m_write), 64'd0);
        chk("rst s0_rdv", 64'(s0_readdatavalid), 64'd0);
        step_b();
        step_a(0, 0, 0, 1, 0, 1, 1, 0, 0);
        chk("post-rst s1_waitrequest", 64'(s1_waitrequest), 64'd0);
        chk("post-rst m_read", 64'(m_read), 64'd1);
        chk("post-rst rsp_err", 64'(rsp_err), 64'd0);
        step_b();
        step_a(0, 0, 0, 0, 0, 1, 1, 0, 1);
        chk("post-rst s1_rdv", 64'(s1_readdatavalid), 64'd1);
        step_b();

        // Grant counters: 5 s0 reads, 3 s1 write bursts of 4
        step(1, 0, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1, 1, 4, 0, 0);
        step_a(0, 0, 0, 0, 0, 1, 1, 0, 0);
`ifdef EMIF_AVMM_ARB_PERF_EN
        chk("perf s0_grant_cnt", 64'(s0_grant_cnt), 64'd5);
        chk("perf s1_grant_cnt", 64'(s1_grant_cnt), 64'd3);
`else
        chk("perf s0_grant_cnt", 64'(s0_grant_cnt), 64'd0);
        chk("perf s1_grant_cnt", 64'(s1_grant_cnt), 64'd0);
`endif
        step_b();

        // Randomized traffic against the model
        step(1, 0, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            int op0, op1;
            bit rst, rdv;
            rst = ($urandom_range(0, 299) == 0);
            op0 = $urandom_range(0, 2);
            op1 = $urandom_range(0, 2);
            rdv = (rq.size() > 0) && ($urandom_range(0, 1) == 1);
            step(rst, op0 == 1, op0 == 2, op1 == 1, op1 == 2,
                 $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 3) == 0, rdv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
